// File: rtl/controle_exibicao_sequencia.sv
// Sequence playback controller for the memory game.
// Walks the sequence memory from address 0 up to a limit latched at start,
// lighting each stored colour for T_ACESO clocks and blanking for
// T_APAGADO clocks, then pulses `fim` for one cycle.
// All outputs come straight from registers; the next value of every register
// is computed in a single combinational block next to the FSM.

module controle_exibicao_sequencia #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 4,
    parameter int T_ACESO   = 500,
    parameter int T_APAGADO = 250
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              abortar,
    input  logic [ADDR_W-1:0] limite,
    input  logic [DATA_W-1:0] dado_memoria,
    output logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] leds,
    output logic              ocupado,
    output logic              fim,
    output logic [3:0]        db_estado
);

    // Timer holds at most max(T_ACESO, T_APAGADO)-1; keep at least one bit
    // so that T_ACESO = T_APAGADO = 1 still elaborates.
    localparam int T_MAX   = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
    localparam int TIMER_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [TIMER_W-1:0] CARGA_ACESO   = TIMER_W'(T_ACESO - 1);
    localparam logic [TIMER_W-1:0] CARGA_APAGADO = TIMER_W'(T_APAGADO - 1);
    localparam logic [TIMER_W-1:0] TIMER_ZERO    = {TIMER_W{1'b0}};
    localparam logic [TIMER_W-1:0] TIMER_UM      = TIMER_W'(1);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        ACESO   = 3'd2,
        APAGADO = 3'd3,
        FIM     = 3'd4
    } estado_t;

    estado_t             state_r;
    estado_t             next_state_s;
    logic [TIMER_W-1:0]  timer_r;
    logic [TIMER_W-1:0]  timer_next_s;
    logic [ADDR_W-1:0]   limite_r;
    logic [ADDR_W-1:0]   limite_next_s;
    logic [ADDR_W-1:0]   endereco_r;
    logic [ADDR_W-1:0]   endereco_next_s;
    logic [DATA_W-1:0]   leds_r;
    logic [DATA_W-1:0]   leds_next_s;
    logic                ocupado_r;
    logic                ocupado_next_s;
    logic                fim_r;
    logic                fim_next_s;
    logic                ultimo_s;
    logic                timer_zero_s;

    assign timer_zero_s = (timer_r == TIMER_ZERO);
    // The limit is compared against the latched copy, so changes on `limite`
    // during a run have no effect.
    assign ultimo_s     = (endereco_r == limite_r);

    // Next-state and next-output logic; abort overrides every transition
    // except while already idle.
    always_comb begin
        next_state_s    = state_r;
        timer_next_s    = timer_r;
        limite_next_s   = limite_r;
        endereco_next_s = endereco_r;
        leds_next_s     = leds_r;

        if (abortar && (state_r != OCIOSO)) begin
            next_state_s = OCIOSO;
            leds_next_s  = {DATA_W{1'b0}};
            timer_next_s = TIMER_ZERO;
        end else begin
            case (state_r)
                OCIOSO: begin
                    leds_next_s  = {DATA_W{1'b0}};
                    timer_next_s = TIMER_ZERO;
                    // Abort held together with start keeps the block idle.
                    if (iniciar && !abortar) begin
                        limite_next_s   = limite;
                        endereco_next_s = {ADDR_W{1'b0}};
                        next_state_s    = CARREGA;
                    end else begin
                        next_state_s    = OCIOSO;
                    end
                end
                CARREGA: begin
                    // Memory read is combinational, so the word for
                    // endereco_r is valid during this cycle.
                    leds_next_s  = dado_memoria;
                    timer_next_s = CARGA_ACESO;
                    next_state_s = ACESO;
                end
                ACESO: begin
                    if (timer_zero_s) begin
                        leds_next_s  = {DATA_W{1'b0}};
                        timer_next_s = CARGA_APAGADO;
                        next_state_s = APAGADO;
                    end else begin
                        timer_next_s = timer_r - TIMER_UM;
                        next_state_s = ACESO;
                    end
                end
                APAGADO: begin
                    leds_next_s = {DATA_W{1'b0}};
                    if (timer_zero_s) begin
                        if (ultimo_s) begin
                            next_state_s = FIM;
                        end else begin
                            // Increment only below the limit, so a limit of
                            // all-ones never wraps back to zero.
                            endereco_next_s = endereco_r + ADDR_W'(1);
                            next_state_s    = CARREGA;
                        end
                    end else begin
                        timer_next_s = timer_r - TIMER_UM;
                        next_state_s = APAGADO;
                    end
                end
                FIM: begin
                    // endereco_r keeps the last displayed address.
                    leds_next_s  = {DATA_W{1'b0}};
                    next_state_s = OCIOSO;
                end
                default: begin
                    leds_next_s  = {DATA_W{1'b0}};
                    timer_next_s = TIMER_ZERO;
                    next_state_s = OCIOSO;
                end
            endcase
        end

        // Status flags are registered copies of the state being entered.
        ocupado_next_s = (next_state_s == CARREGA) ||
                         (next_state_s == ACESO)   ||
                         (next_state_s == APAGADO);
        fim_next_s     = (next_state_s == FIM);
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= OCIOSO;
            timer_r    <= TIMER_ZERO;
            limite_r   <= {ADDR_W{1'b0}};
            endereco_r <= {ADDR_W{1'b0}};
            leds_r     <= {DATA_W{1'b0}};
            ocupado_r  <= 1'b0;
            fim_r      <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            timer_r    <= timer_next_s;
            limite_r   <= limite_next_s;
            endereco_r <= endereco_next_s;
            leds_r     <= leds_next_s;
            ocupado_r  <= ocupado_next_s;
            fim_r      <= fim_next_s;
        end
    end

    assign endereco  = endereco_r;
    assign leds      = leds_r;
    assign ocupado   = ocupado_r;
    assign fim       = fim_r;
    assign db_estado = {1'b0, state_r};

endmodule

// File: doc/controle_exibicao_sequencia.md
Name: controle_exibicao_sequencia

Overview:
Sequencer that plays the stored game sequence back on the LEDs for the memory-game datapath. On `iniciar` it walks the sequence memory from address 0 to the round limit. Each element is lit for T_ACESO clocks, then blanked for T_APAGADO clocks. When the last element is done it pulses `fim` to the game control unit, which then enters the player-input/timeout phase.

Parameters:
ADDR_W, 4, width of the memory address and of the round limit
DATA_W, 4, width of a memory word and of the LED vector (one-hot colour)
T_ACESO, 500, clocks each element stays lit (500 ms at the 1 kHz game clock); must be >= 1
T_APAGADO, 250, clocks of blank gap after each element; must be >= 1

Ports:
clock  input  1  game clock, rising edge
reset  input  1  asynchronous, active-low reset
iniciar  input  1  start request, sampled only in OCIOSO
abortar  input  1  synchronous abort, returns to OCIOSO
limite  input  ADDR_W  last address to display (inclusive)
dado_memoria  input  DATA_W  memory word at `endereco` (combinational read, valid same cycle)
endereco  output  ADDR_W  current read address
leds  output  DATA_W  LED drive
ocupado  output  1  high from CARREGA through APAGADO of the last element
fim  output  1  one-cycle completion pulse
db_estado  output  4  state encoding for the debug display

Behaviour:
- Reset (`reset`=0), asynchronous:
  - state OCIOSO.
  - `endereco`, `leds`, `ocupado`, `fim`, internal timer and latched limit all 0.
  - No clock edge is needed for outputs to clear.
- States and `db_estado` codes: OCIOSO=0, CARREGA=1, ACESO=2, APAGADO=3, FIM=4. Unused codes go to OCIOSO.
- OCIOSO:
  - `leds`=0, `ocupado`=0.
  - If `iniciar`=1 at the edge: latch `limite`, set `endereco`=0, go to CARREGA.
- CARREGA (1 cycle):
  - At the edge: `leds` <= `dado_memoria`, timer <= T_ACESO-1, go to ACESO.
- ACESO:
  - `leds` held.
  - Timer decrements each edge. At timer=0: `leds` <= 0, timer <= T_APAGADO-1, go to APAGADO.
  - `leds` is therefore non-zero for exactly T_ACESO cycles.
- APAGADO:
  - `leds`=0, timer decrements.
  - At timer=0: if `endereco` == latched limit, go to FIM; else `endereco` +1 and go to CARREGA.
- FIM (1 cycle):
  - `fim`=1, `ocupado`=0, then go to OCIOSO.
  - `endereco` keeps the last value until the next start.
- `ocupado`=1 in CARREGA, ACESO and APAGADO.
- Latency from the edge sampling `iniciar` to the `fim` cycle is 1 + (limite+1)*(1+T_ACESO+T_APAGADO) clocks.
- Boundary conditions:
  - `iniciar` outside OCIOSO is ignored and does not restart.
  - `limite` changes after start are ignored; the value latched at start is used.
  - limite=0 displays exactly one element.
  - limite = 2^ADDR_W - 1 displays all addresses with no wrap; `endereco` never increments past the limit.
  - A zero memory word shows dark LEDs with unchanged timing.
  - `abortar`=1 at any edge outside OCIOSO: next state OCIOSO, `leds`=0, `ocupado`=0, no `fim` pulse. `abortar` takes priority over all transitions.
  - `abortar` and `iniciar` both high in OCIOSO: stay in OCIOSO.
  - Reset mid-operation clears everything immediately. No `fim` is produced.
- Timer width is clog2(max(T_ACESO, T_APAGADO)) bits; no arithmetic overflow is possible.

Test Plan:
- Use T_ACESO=4, T_APAGADO=2 in the bench.
1. Reset hold: `reset`=0 mid-simulation with random inputs -> all outputs 0 asynchronously, `db_estado`=0.
2. Single element: mem[0]=0001, limite=0, one-cycle `iniciar` -> `leds`=0001 exactly cycles 2–5 after the sample edge, 0 in cycles 6–7, `fim`=1 only in cycle 8, `ocupado`=1 in cycles 1–7.
3. Full round: mem = 0001, 0010, 0100, 1000 at addresses 0–3, limite=3 -> `endereco` steps 0,1,2,3; LED pattern repeats every 7 cycles; single `fim` at cycle 29.
4. Ignored inputs: during the run of scenario 3, change limite to 1 and pulse `iniciar` twice -> identical waveform to scenario 3, `fim` still at cycle 29.
5. Abort: `abortar` pulse while element 2 is in ACESO -> next cycle OCIOSO, `leds`=0, no `fim`. A fresh `iniciar` restarts at `endereco`=0.
6. Async reset mid-ACESO: drop `reset` between clock edges -> `leds` and `ocupado` fall before the next edge. After release, a new `iniciar` runs normally.
